// File: rtl/cpu7_ifu_fcl_pkg.sv
// rtl/cpu7_ifu_fcl_pkg.sv - shared types and defaults for the IFU fetch control logic
package cpu7_ifu_fcl_pkg;

  localparam int FCL_MAX_OUTST = 2;
  localparam int FCL_CNT_W     = 2;

  typedef enum logic [1:0] {
    FCL_INIT  = 2'd0,
    FCL_RUN   = 2'd1,
    FCL_DRAIN = 2'd2
  } fcl_state_e;

  // Active-high view of the pc_bf mux selects, MSB first: init, old, pcinc, brpc, excpc
  typedef struct packed {
    logic init;
    logic old;
    logic pcinc;
    logic brpc;
    logic excpc;
  } fcl_sel_t;

  function automatic logic [4:0] fcl_sel_l(input fcl_sel_t s);
    return ~s;
  endfunction

endpackage

// File: rtl/cpu7_ifu_fcl_cnt.sv
// rtl/cpu7_ifu_fcl_cnt.sv - up/down counter with load, saturating at 0 and MAX
module cpu7_ifu_fcl_cnt #(
  parameter int W   = 2,
  parameter int MAX = 2
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MaxV = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over inc/dec; simultaneous inc and dec cancel out
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val > MaxV) ? MaxV : load_val;
    end else if (inc && !dec) begin
      if (cnt_q != MaxV) cnt_d = cnt_q + W'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu7_ifu_fcl.sv
// rtl/cpu7_ifu_fcl.sv - IFU fetch control: pc_bf select decode, bus request/cancel,
// outstanding-request tracking and stale-response discard after redirects
module cpu7_ifu_fcl
  import cpu7_ifu_fcl_pkg::*;
#(
  parameter int MAX_OUTST = FCL_MAX_OUTST,
  parameter int CNT_W     = FCL_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  output logic             inst_req,
  input  logic             inst_addr_ok,
  input  logic             inst_valid,
  output logic             inst_cancel,
  input  logic             br_taken,
  input  logic             exu_ifu_except,
  input  logic             exu_ifu_stall_req,
  output logic             fcl_fdp_sel_init_bf_l,
  output logic             fcl_fdp_sel_old_bf_l,
  output logic             fcl_fdp_sel_pcinc_bf_l,
  output logic             fcl_fdp_sel_brpc_bf_l,
  output logic             fcl_fdp_sel_excpc_bf_l,
  output logic             fcl_fdp_dec_valid,
  output logic             fcl_fdp_pc_f2d_en,
  output logic [CNT_W-1:0] fcl_outst_cnt
);

  localparam logic [CNT_W-1:0] MaxOutst = CNT_W'(MAX_OUTST);

  fcl_state_e       state_q, state_d;
  logic [CNT_W-1:0] outst, drop, drop_load;
  logic             active, redirect, good, req, drop_zero;
  fcl_sel_t         sel;
  logic [4:0]       sel_l;

  // Redirects and responses are ignored until the PC has been initialised
  assign active    = (state_q != FCL_INIT);
  assign redirect  = active && (exu_ifu_except || br_taken);
  assign drop_zero = (drop == '0);
  assign good      = active && inst_valid && drop_zero && !exu_ifu_except &&
                     !br_taken && !exu_ifu_stall_req;
  assign req       = active && (outst < MaxOutst) && !exu_ifu_stall_req;

  // A response arriving with the redirect is itself stale, so it is not counted
  assign drop_load = (inst_valid && outst != '0) ? outst - CNT_W'(1) : outst;

  cpu7_ifu_fcl_cnt #(.W(CNT_W), .MAX(MAX_OUTST)) u_outst_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .inc      (req && inst_addr_ok),
    .dec      (inst_valid),
    .load     (1'b0),
    .load_val ('0),
    .cnt      (outst)
  );

  cpu7_ifu_fcl_cnt #(.W(CNT_W), .MAX(MAX_OUTST)) u_drop_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .inc      (1'b0),
    .dec      (inst_valid && !drop_zero),
    .load     (redirect),
    .load_val (drop_load),
    .cnt      (drop)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FCL_INIT: state_d = FCL_RUN;
      FCL_RUN, FCL_DRAIN: begin
        if (redirect) begin
          state_d = (drop_load != '0) ? FCL_DRAIN : FCL_RUN;
        end else if (state_q == FCL_DRAIN &&
                     (drop_zero || (inst_valid && drop == CNT_W'(1)))) begin
          state_d = FCL_RUN;
        end
      end
      default: state_d = FCL_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= FCL_INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    sel = '0;
    if (!active)                sel.init  = 1'b1;
    else if (exu_ifu_except)    sel.excpc = 1'b1;
    else if (br_taken)          sel.brpc  = 1'b1;
    else if (exu_ifu_stall_req) sel.old   = 1'b1;
    else if (good)              sel.pcinc = 1'b1;
    else                        sel.old   = 1'b1;
  end

  assign sel_l                  = fcl_sel_l(sel);
  assign fcl_fdp_sel_init_bf_l  = sel_l[4];
  assign fcl_fdp_sel_old_bf_l   = sel_l[3];
  assign fcl_fdp_sel_pcinc_bf_l = sel_l[2];
  assign fcl_fdp_sel_brpc_bf_l  = sel_l[1];
  assign fcl_fdp_sel_excpc_bf_l = sel_l[0];

  assign inst_req          = req;
  assign inst_cancel       = redirect;
  assign fcl_fdp_dec_valid = good;
  assign fcl_fdp_pc_f2d_en = good;
  assign fcl_outst_cnt     = outst;

  always @(posedge clock) begin
    if (resetn) begin
      assert ($onehot(~sel_l));
      assert (outst <= MaxOutst);
      assert (drop <= outst);
      assert (!(inst_valid && outst == '0));
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// tb/tb_cpu7_ifu_fcl.sv - directed scoreboard bench for cpu7_ifu_fcl
module tb_cpu7_ifu_fcl;

  localparam logic [4:0] S_INIT = 5'b01111;
  localparam logic [4:0] S_OLD  = 5'b10111;
  localparam logic [4:0] S_INC  = 5'b11011;
  localparam logic [4:0] S_BR   = 5'b11101;
  localparam logic [4:0] S_EXC  = 5'b11110;

  typedef struct {
    string      tag;
    logic [4:0] sel_l;
    logic       req;
    logic       cancel;
    logic       dv;
    logic [1:0] outst;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       inst_req, inst_addr_ok, inst_valid, inst_cancel;
  logic       br_taken, exu_ifu_except, exu_ifu_stall_req;
  logic       sel_init_l, sel_old_l, sel_pcinc_l, sel_brpc_l, sel_excpc_l;
  logic       dec_valid, f2d_en;
  logic [1:0] outst_cnt;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  cpu7_ifu_fcl dut (
    .clock                  (clock),
    .resetn                 (resetn),
    .inst_req               (inst_req),
    .inst_addr_ok           (inst_addr_ok),
    .inst_valid             (inst_valid),
    .inst_cancel            (inst_cancel),
    .br_taken               (br_taken),
    .exu_ifu_except         (exu_ifu_except),
    .exu_ifu_stall_req      (exu_ifu_stall_req),
    .fcl_fdp_sel_init_bf_l  (sel_init_l),
    .fcl_fdp_sel_old_bf_l   (sel_old_l),
    .fcl_fdp_sel_pcinc_bf_l (sel_pcinc_l),
    .fcl_fdp_sel_brpc_bf_l  (sel_brpc_l),
    .fcl_fdp_sel_excpc_bf_l (sel_excpc_l),
    .fcl_fdp_dec_valid      (dec_valid),
    .fcl_fdp_pc_f2d_en      (f2d_en),
    .fcl_outst_cnt          (outst_cnt)
  );

  task automatic step(input string tag,
                      input logic ok, input logic vld, input logic br,
                      input logic exc, input logic stl,
                      input logic [4:0] s, input logic req, input logic cancel,
                      input logic dv, input logic [1:0] outst);
    exp_t       e;
    exp_t       got;
    logic [8:0] obs_v, exp_v;
    inst_addr_ok      = ok;
    inst_valid        = vld;
    br_taken          = br;
    exu_ifu_except    = exc;
    exu_ifu_stall_req = stl;
    e = '{tag: tag, sel_l: s, req: req, cancel: cancel, dv: dv, outst: outst};
    sb.push_back(e);
    @(negedge clock);
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end
    if (sb.size() != 0) begin
      got   = sb.pop_front();
      obs_v = {sel_init_l, sel_old_l, sel_pcinc_l, sel_brpc_l, sel_excpc_l,
               inst_req, inst_cancel, dec_valid, f2d_en};
      exp_v = {got.sel_l, got.req, got.cancel, got.dv, got.dv};
      n_assert++;
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s sel/req/cancel/dv/f2d observed=%b expected=%b", got.tag, obs_v, exp_v);
      end
      n_assert++;
      assert (outst_cnt === got.outst) else begin
        n_fail++;
        $error("FAIL %s outst observed=%0d expected=%0d", got.tag, outst_cnt, got.outst);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    inst_addr_ok = 0; inst_valid = 0; br_taken = 0;
    exu_ifu_except = 0; exu_ifu_stall_req = 0;
    @(posedge clock); #1;

    // reset and first fetch
    step("rst",       0,0,0,0,0, S_INIT, 0,0,0, 2'd0);
    resetn = 1'b1;
    step("init",      0,0,0,0,0, S_INIT, 0,0,0, 2'd0);
    step("run_req",   1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("wait_rsp",  0,0,0,0,0, S_OLD,  1,0,0, 2'd1);
    step("first_ok",  0,1,0,0,0, S_INC,  1,0,1, 2'd1);

    // back-to-back accept saturates outstanding count
    step("acc1",      1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("acc2",      1,0,0,0,0, S_OLD,  1,0,0, 2'd1);
    step("full",      0,0,0,0,0, S_OLD,  0,0,0, 2'd2);
    step("rsp_full",  0,1,0,0,0, S_INC,  0,0,1, 2'd2);
    step("one_left",  0,0,0,0,0, S_OLD,  1,0,0, 2'd1);
    step("refill",    1,0,0,0,0, S_OLD,  1,0,0, 2'd1);

    // branch with two in flight: both responses dropped
    step("br",        0,0,1,0,0, S_BR,   0,1,0, 2'd2);
    step("drop1",     0,1,0,0,0, S_OLD,  0,0,0, 2'd2);
    step("drain_idle",0,0,0,0,0, S_OLD,  1,0,0, 2'd1);
    step("drop2",     0,1,0,0,0, S_OLD,  1,0,0, 2'd1);
    step("post_acc",  1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("post_ok",   0,1,0,0,0, S_INC,  1,0,1, 2'd1);

    // except and branch together with a response in the same cycle
    step("pre_exc",   1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("exc_br",    0,1,1,1,0, S_EXC,  1,1,0, 2'd1);
    step("exc_idle",  1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("exc_ok",    0,1,0,0,0, S_INC,  1,0,1, 2'd1);

    // stall holds PC and blocks requests while responses still drain the counter
    step("st_acc1",   1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("st_acc2",   1,0,0,0,0, S_OLD,  1,0,0, 2'd1);
    step("stall1",    0,1,0,0,1, S_OLD,  0,0,0, 2'd2);
    step("stall2",    0,1,0,0,1, S_OLD,  0,0,0, 2'd1);
    step("stall3",    1,0,0,0,1, S_OLD,  0,0,0, 2'd0);
    step("unstall",   1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("unstall_ok",0,1,0,0,0, S_INC,  1,0,1, 2'd1);

    // redirect while draining reloads the drop count
    step("d_acc1",    1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("d_acc2",    1,0,0,0,0, S_OLD,  1,0,0, 2'd1);
    step("d_br",      0,0,1,0,0, S_BR,   0,1,0, 2'd2);
    step("d_drop",    0,1,0,0,0, S_OLD,  0,0,0, 2'd2);
    step("d_exc",     1,0,0,1,0, S_EXC,  1,1,0, 2'd1);

    // asynchronous reset mid-drain; redirect inputs must be ignored
    resetn = 1'b0;
    step("rst_mid",   0,1,1,0,0, S_INIT, 0,0,0, 2'd0);
    resetn = 1'b1;
    step("init2",     0,0,0,0,0, S_INIT, 0,0,0, 2'd0);
    step("run2_acc",  1,0,0,0,0, S_OLD,  1,0,0, 2'd0);
    step("run2_ok",   0,1,0,0,0, S_INC,  1,0,1, 2'd1);
    step("run2_idle", 0,0,0,0,0, S_OLD,  1,0,0, 2'd0);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
